alu_arbiter: RTL and testbench

ALU_ARBITER -- requirements
Module: alu_arbiter

---
 rtl/alu_arbiter_if.sv | 56 +++++
 rtl/alu_arbiter.sv | 105 ++++++++++
 tb/tb_alu_arbiter.sv | 235 +++++++++++++++++++++++
 3 files changed

// File: rtl/alu_arbiter_if.sv
// alu_arbiter_if -- bundle of every non-clock/reset signal of alu_arbiter.
//   Requester ports 0/1 : reqN_valid/a/b/op in, reqN_ready out
//   Response ports 0/1  : rspN_valid out, rspN_ready in, shared rsp_result/zero/err out
//   Shared ALU          : alu_a/alu_b/alu_ctrl out, alu_result/alu_zero in
//   Status              : done_cnt0/done_cnt1 (CNTW bits), busy
// modport slave is the arbiter side; modport master is the environment side.
interface alu_arbiter_if #(
    parameter int WIDTH = 32,
    parameter int CNTW  = 16
);
    logic             req0_valid;
    logic [WIDTH-1:0] req0_a;
    logic [WIDTH-1:0] req0_b;
    logic [2:0]       req0_op;
    logic             req0_ready;
    logic             req1_valid;
    logic [WIDTH-1:0] req1_a;
    logic [WIDTH-1:0] req1_b;
    logic [2:0]       req1_op;
    logic             req1_ready;
    logic             rsp0_valid;
    logic             rsp1_valid;
    logic             rsp0_ready;
    logic             rsp1_ready;
    logic [WIDTH-1:0] rsp_result;
    logic             rsp_zero;
    logic             rsp_err;
    logic [WIDTH-1:0] alu_a;
    logic [WIDTH-1:0] alu_b;
    logic [2:0]       alu_ctrl;
    logic [WIDTH-1:0] alu_result;
    logic             alu_zero;
    logic [CNTW-1:0]  done_cnt0;
    logic [CNTW-1:0]  done_cnt1;
    logic             busy;

    modport slave (
        input  req0_valid, req0_a, req0_b, req0_op,
        input  req1_valid, req1_a, req1_b, req1_op,
        input  rsp0_ready, rsp1_ready, alu_result, alu_zero,
        output req0_ready, req1_ready, rsp0_valid, rsp1_valid,
        output rsp_result, rsp_zero, rsp_err,
        output alu_a, alu_b, alu_ctrl,
        output done_cnt0, done_cnt1, busy
    );

    modport master (
        output req0_valid, req0_a, req0_b, req0_op,
        output req1_valid, req1_a, req1_b, req1_op,
        output rsp0_ready, rsp1_ready, alu_result, alu_zero,
        input  req0_ready, req1_ready, rsp0_valid, rsp1_valid,
        input  rsp_result, rsp_zero, rsp_err,
        input  alu_a, alu_b, alu_ctrl,
        input  done_cnt0, done_cnt1, busy
    );
endinterface

// File: rtl/alu_arbiter.sv
// alu_arbiter -- two-requester round-robin front end for one shared
// combinational ALU. One transaction in flight: IDLE (accept) -> EXEC
// (capture ALU output) -> RESP (hold response until consumed).
//   clk   : clock
//   reset : asynchronous, active-high
//   bus   : alu_arbiter_if.slave (request, response, ALU and status signals)
module alu_arbiter #(
    parameter int WIDTH = 32,
    parameter int CNTW  = 16
) (
    input  logic         clk,
    input  logic         reset,
    alu_arbiter_if.slave bus
);
    typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

    state_t           state, state_nxt;
    logic             last_grant;
    logic             grant;
    logic             owner;
    logic [WIDTH-1:0] a_q, b_q;
    logic [2:0]       op_q;
    logic [WIDTH-1:0] result_q;
    logic             zero_q, err_q;
    logic [CNTW-1:0]  cnt0, cnt1;
    logic             accept, rsp_take;

    // Single valid wins outright; tie or no request points at the other port
    // so readiness keeps alternating.
    always_comb begin
        grant = ~last_grant;
        if (bus.req0_valid && !bus.req1_valid)
            grant = 1'b0;
        else if (bus.req1_valid && !bus.req0_valid)
            grant = 1'b1;
    end

    assign accept   = (state == IDLE) && (grant ? bus.req1_valid : bus.req0_valid);
    assign rsp_take = (state == RESP) && (owner ? bus.rsp1_ready : bus.rsp0_ready);

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (accept) state_nxt = EXEC;
            EXEC:    state_nxt = RESP;
            RESP:    if (rsp_take) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            last_grant <= 1'b1;
            owner      <= 1'b0;
            a_q        <= '0;
            b_q        <= '0;
            op_q       <= '0;
            result_q   <= '0;
            zero_q     <= 1'b0;
            err_q      <= 1'b0;
            cnt0       <= '0;
            cnt1       <= '0;
        end else begin
            if (accept) begin
                owner      <= grant;
                last_grant <= grant;
                a_q        <= grant ? bus.req1_a  : bus.req0_a;
                b_q        <= grant ? bus.req1_b  : bus.req0_b;
                op_q       <= grant ? bus.req1_op : bus.req0_op;
            end
            if (state == EXEC) begin
                result_q <= bus.alu_result;
                zero_q   <= bus.alu_zero;
                err_q    <= (op_q == 3'b100) || (op_q == 3'b110) || (op_q == 3'b111);
            end
            if (rsp_take) begin
                if (!owner && cnt0 != '1) cnt0 <= cnt0 + CNTW'(1);
                if (owner  && cnt1 != '1) cnt1 <= cnt1 + CNTW'(1);
            end
        end
    end

    // Reset forces state to IDLE, but readiness must also be low while reset
    // is held, so it is gated explicitly.
    assign bus.req0_ready = !reset && (state == IDLE) && !grant;
    assign bus.req1_ready = !reset && (state == IDLE) &&  grant;
    assign bus.rsp0_valid = (state == RESP) && !owner;
    assign bus.rsp1_valid = (state == RESP) &&  owner;
    assign bus.rsp_result = result_q;
    assign bus.rsp_zero   = zero_q;
    assign bus.rsp_err    = err_q;
    assign bus.alu_a      = a_q;
    assign bus.alu_b      = b_q;
    assign bus.alu_ctrl   = op_q;
    assign bus.done_cnt0  = cnt0;
    assign bus.done_cnt1  = cnt1;
    assign bus.busy       = (state != IDLE);
endmodule

// File: tb/tb_alu_arbiter.sv
// tb_alu_arbiter -- directed vector table plus hand-written multi-cycle
// sequences for alu_arbiter, with a behavioural ALU attached.
// ALU codes used here: 000 add, 001 sub, 010 and, 011 or, 101 xor;
// anything else yields 0.
module tb_alu_arbiter;
    localparam int W       = 32;
    localparam int CW      = 2;
    localparam int CNT_MAX = 3;

    logic clk;
    logic reset;
    int   n_tests;
    int   n_fail;
    int   exp_cnt[2];

    alu_arbiter_if #(.WIDTH(W), .CNTW(CW)) bus ();

    alu_arbiter #(.WIDTH(W), .CNTW(CW)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always_comb begin
        case (bus.alu_ctrl)
            3'b000:  bus.alu_result = bus.alu_a + bus.alu_b;
            3'b001:  bus.alu_result = bus.alu_a - bus.alu_b;
            3'b010:  bus.alu_result = bus.alu_a & bus.alu_b;
            3'b011:  bus.alu_result = bus.alu_a | bus.alu_b;
            3'b101:  bus.alu_result = bus.alu_a ^ bus.alu_b;
            default: bus.alu_result = '0;
        endcase
        bus.alu_zero = (bus.alu_result == '0);
    end

    typedef struct {
        logic        port;
        logic [2:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] res;
        logic        zero;
        logic        err;
    } vec_t;

    vec_t vecs[10];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic set_req(input logic port, input logic v, input logic [2:0] op,
                           input logic [31:0] a, input logic [31:0] b);
        if (port) begin
            bus.req1_valid = v; bus.req1_op = op; bus.req1_a = a; bus.req1_b = b;
        end else begin
            bus.req0_valid = v; bus.req0_op = op; bus.req0_a = a; bus.req0_b = b;
        end
    endtask

    task automatic bump(input logic port);
        if (exp_cnt[port] < CNT_MAX) exp_cnt[port]++;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        exp_cnt[0] = 0;
        exp_cnt[1] = 0;
    endtask

    // Full single-port transaction; entered and left at edge+1 in IDLE.
    task automatic run_txn(input vec_t v);
        set_req(v.port, 1'b1, v.op, v.a, v.b);
        #1;
        chk("ready_owner", v.port ? bus.req1_ready : bus.req0_ready, 1);
        chk("ready_other", v.port ? bus.req0_ready : bus.req1_ready, 0);
        @(posedge clk); #1;
        set_req(v.port, 1'b0, 3'b000, '0, '0);
        chk("exec_busy", bus.busy, 1);
        chk("exec_rsp_valid", {bus.rsp1_valid, bus.rsp0_valid}, 0);
        @(posedge clk); #1;
        chk("rsp_valid_owner", v.port ? bus.rsp1_valid : bus.rsp0_valid, 1);
        chk("rsp_valid_other", v.port ? bus.rsp0_valid : bus.rsp1_valid, 0);
        chk("rsp_result", bus.rsp_result, v.res);
        chk("rsp_zero", bus.rsp_zero, v.zero);
        chk("rsp_err", bus.rsp_err, v.err);
        if (v.port) bus.rsp1_ready = 1'b1; else bus.rsp0_ready = 1'b1;
        @(posedge clk); #1;
        bus.rsp0_ready = 1'b0;
        bus.rsp1_ready = 1'b0;
        bump(v.port);
        chk("done_busy", bus.busy, 0);
        chk("done_cnt0", bus.done_cnt0, exp_cnt[0]);
        chk("done_cnt1", bus.done_cnt1, exp_cnt[1]);
    endtask

    initial begin
        n_tests = 0;
        n_fail  = 0;
        exp_cnt[0] = 0;
        exp_cnt[1] = 0;
        vecs[0] = '{1'b0, 3'b000, 32'd5,        32'd7,        32'd12,       1'b0, 1'b0};
        vecs[1] = '{1'b1, 3'b001, 32'd10,       32'd3,        32'd7,        1'b0, 1'b0};
        vecs[2] = '{1'b0, 3'b010, 32'h0000F0F0, 32'h0000FF00, 32'h0000F000, 1'b0, 1'b0};
        vecs[3] = '{1'b1, 3'b011, 32'h12000000, 32'h00000034, 32'h12000034, 1'b0, 1'b0};
        vecs[4] = '{1'b0, 3'b101, 32'hAAAA5555, 32'hAAAA5555, 32'h0,        1'b1, 1'b0};
        vecs[5] = '{1'b1, 3'b000, 32'hFFFFFFFF, 32'd1,        32'h0,        1'b1, 1'b0};
        vecs[6] = '{1'b0, 3'b110, 32'd3,        32'd4,        32'h0,        1'b1, 1'b1};
        vecs[7] = '{1'b1, 3'b100, 32'd8,        32'd2,        32'h0,        1'b1, 1'b1};
        vecs[8] = '{1'b0, 3'b111, 32'd1,        32'd2,        32'h0,        1'b1, 1'b1};
        vecs[9] = '{1'b1, 3'b001, 32'd1,        32'd2,        32'hFFFFFFFF, 1'b0, 1'b0};

        set_req(1'b0, 1'b0, 3'b000, '0, '0);
        set_req(1'b1, 1'b0, 3'b000, '0, '0);
        bus.rsp0_ready = 1'b0;
        bus.rsp1_ready = 1'b0;

        // Reset values while reset is held, with a request pending.
        reset = 1'b1;
        bus.req0_valid = 1'b1;
        #2;
        chk("rst_req0_ready", bus.req0_ready, 0);
        chk("rst_req1_ready", bus.req1_ready, 0);
        chk("rst_busy", bus.busy, 0);
        chk("rst_rsp_valid", {bus.rsp1_valid, bus.rsp0_valid}, 0);
        chk("rst_result", bus.rsp_result, 0);
        chk("rst_flags", {bus.rsp_zero, bus.rsp_err}, 0);
        chk("rst_cnt", {bus.done_cnt1, bus.done_cnt0}, 0);
        chk("rst_alu_in", bus.alu_a | bus.alu_b | 32'(bus.alu_ctrl), 0);
        bus.req0_valid = 1'b0;
        @(posedge clk); #1;
        reset = 1'b0;

        // Tie after reset, continuous contention, backpressure.
        set_req(1'b0, 1'b1, 3'b001, 32'd9, 32'd9);
        set_req(1'b1, 1'b1, 3'b011, 32'hF0, 32'h0F);
        #1;
        chk("tie_req0_ready", bus.req0_ready, 1);
        chk("tie_req1_ready", bus.req1_ready, 0);
        @(posedge clk); #1;
        chk("tie_exec_ready", {bus.req1_ready, bus.req0_ready}, 0);
        @(posedge clk); #1;
        chk("tie_rsp0_valid", bus.rsp0_valid, 1);
        chk("tie_rsp0_result", bus.rsp_result, 0);
        chk("tie_rsp0_zero", bus.rsp_zero, 1);
        chk("tie_resp_ready", {bus.req1_ready, bus.req0_ready}, 0);
        bus.rsp0_ready = 1'b1;
        @(posedge clk); #1;
        bus.rsp0_ready = 1'b0;
        chk("tie_cnt0", bus.done_cnt0, 1);
        chk("alt_req1_ready", bus.req1_ready, 1);
        chk("alt_req0_ready", bus.req0_ready, 0);
        @(posedge clk); #1;
        bus.req1_valid = 1'b0;
        @(posedge clk); #1;
        chk("tie_rsp1_valid", bus.rsp1_valid, 1);
        chk("tie_rsp1_result", bus.rsp_result, 32'hFF);
        chk("tie_rsp1_zero", bus.rsp_zero, 0);
        bus.rsp0_ready = 1'b1;
        bus.req1_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            chk("bp_rsp1_valid", bus.rsp1_valid, 1);
            chk("bp_rsp0_valid", bus.rsp0_valid, 0);
            chk("bp_result", bus.rsp_result, 32'hFF);
            chk("bp_flags", {bus.rsp_zero, bus.rsp_err}, 0);
            chk("bp_ready", {bus.req1_ready, bus.req0_ready}, 0);
            chk("bp_busy", bus.busy, 1);
            chk("bp_cnt1", bus.done_cnt1, 0);
        end
        bus.rsp0_ready = 1'b0;
        bus.req1_valid = 1'b0;
        bus.rsp1_ready = 1'b1;
        @(posedge clk); #1;
        bus.rsp1_ready = 1'b0;
        chk("bp_done_cnt1", bus.done_cnt1, 1);
        chk("bp_done_cnt0", bus.done_cnt0, 1);
        chk("alt_back_to_0", bus.req0_ready, 1);
        bus.req0_valid = 1'b0;
        @(posedge clk); #1;
        chk("drop_valid_idle", bus.busy, 0);

        // Table-driven transactions.
        do_reset();
        for (int i = 0; i < 10; i++) run_txn(vecs[i]);

        // Reset while a response is pending.
        set_req(1'b0, 1'b1, 3'b000, 32'd1, 32'd1);
        @(posedge clk); #1;
        set_req(1'b0, 1'b0, 3'b000, '0, '0);
        @(posedge clk); #1;
        chk("mid_rsp0_valid_before", bus.rsp0_valid, 1);
        bus.rsp0_ready = 1'b1;
        reset = 1'b1;
        #1;
        chk("mid_rsp0_valid_async", bus.rsp0_valid, 0);
        chk("mid_busy", bus.busy, 0);
        chk("mid_result", bus.rsp_result, 0);
        chk("mid_cnt", {bus.done_cnt1, bus.done_cnt0}, 0);
        bus.rsp0_ready = 1'b0;
        @(posedge clk); #1;
        reset = 1'b0;
        exp_cnt[0] = 0;
        exp_cnt[1] = 0;
        chk("mid_cnt_after", {bus.done_cnt1, bus.done_cnt0}, 0);
        set_req(1'b0, 1'b1, 3'b000, 32'd2, 32'd2);
        set_req(1'b1, 1'b1, 3'b000, 32'd3, 32'd3);
        #1;
        chk("mid_tie_req0_ready", bus.req0_ready, 1);
        chk("mid_tie_req1_ready", bus.req1_ready, 0);
        set_req(1'b0, 1'b0, 3'b000, '0, '0);
        set_req(1'b1, 1'b0, 3'b000, '0, '0);
        @(posedge clk); #1;
        chk("mid_no_accept", bus.busy, 0);

        // Counter saturation on port 1.
        do_reset();
        for (int i = 0; i < 5; i++)
            run_txn('{1'b1, 3'b000, 32'(i), 32'd1, 32'(i + 1), 1'b0, 1'b0});
        chk("sat_cnt1", bus.done_cnt1, 3);
        chk("sat_cnt0", bus.done_cnt0, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
